mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the core's data bus, downstream of the core's load/store path. Stores to its data register push bytes into a small FIFO; an internal serializer drains the FIFO onto a single 8N1 TX line. Loads from its status register return FIFO/serializer state combinationally in the same cycle, matching the core's single-cycle `data_in` expectation.

---
 rtl/mmio_uart_tx.sv | 203 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a small byte FIFO that a
// serializer drains LSB first; STATUS reads back FIFO and serializer state combinationally.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        tx,
    output logic        tx_busy
);

    localparam int              PTR_W       = $clog2(FIFO_DEPTH);
    localparam int              CNT_W       = PTR_W + 1;
    localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [15:0]     BAUD_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic hit_data;
    logic hit_status;
    logic push_req;
    logic clear_req;

    assign hit_data   = (address == BASE_ADDR);
    assign hit_status = (address == STATUS_ADDR);
    assign sel        = hit_data | hit_status;
    assign push_req   = we & hit_data;
    assign clear_req  = we & hit_status & wdata[3];

    logic unused_wdata_bits;
    assign unused_wdata_bits = &{1'b0, wdata[31:8]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;

    state_t state_reg;
    state_t state_next;

    assign fifo_full  = (count_reg == DEPTH_CNT);
    assign fifo_empty = (count_reg == '0);
    // The serializer only pops from IDLE, so a byte pushed into an empty FIFO waits one edge.
    assign pop        = (state_reg == IDLE) & ~fifo_empty;
    // A full FIFO still accepts a push on the same edge the serializer frees a slot.
    assign push       = push_req & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push_req && !push) begin
                overflow_reg <= 1'b1;
            end else if (clear_req) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    logic        tx_reg;
    logic        tx_next;
    logic [15:0] baud_reg;
    logic [15:0] baud_next;
    logic [2:0]  bit_reg;
    logic [2:0]  bit_next;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_next;
    logic        baud_wrap;

    assign baud_wrap = (baud_reg == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            tx_reg    <= tx_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tx_next    = tx_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (pop) begin
                    shift_next = mem[rd_ptr_reg];
                    tx_next    = 1'b0;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    tx_next    = shift_reg[0];
                    bit_next   = '0;
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                        bit_next   = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign tx      = tx_reg;
    assign tx_busy = (state_reg != IDLE);

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    logic [31:0] status_word;

    assign status_word = {24'd0, 4'(count_reg), overflow_reg, tx_busy, fifo_empty, fifo_full};
    assign rdata       = hit_status ? status_word : 32'd0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized scoreboard bench for mmio_uart_tx: a queue-based transmitter model predicts
// FIFO occupancy, drops and frame start times; a line monitor decodes tx and checks frames.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          C    = 4;
    localparam int          D    = 4;
    localparam int          FRAME = 10 * C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic [31:0] rdata;
    logic        sel;
    logic        tx;
    logic        tx_busy;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .address(address),
        .wdata  (wdata),
        .we     (we),
        .rdata  (rdata),
        .sel    (sel),
        .tx     (tx),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] data;
        longint     start;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_fifo[$];
    longint     cyc = 0;
    longint     m_free_at = 0;
    bit         m_ovf = 1'b0;
    bit         m_busy = 1'b0;
    bit         mon_abort = 1'b0;

    function automatic logic [31:0] model_status();
        return {24'd0, 4'(m_fifo.size()), m_ovf, m_busy, m_fifo.size() == 0, m_fifo.size() == D};
    endfunction

    // One posedge = one edge index; a frame holds the serializer for FRAME cycles plus one idle cycle.
    always @(posedge clk) begin
        longint e;
        bit     pop_now;
        bit     was_full;
        e = cyc;
        if (reset) begin
            m_fifo.delete();
            exp_q.delete();
            m_ovf     = 1'b0;
            m_free_at = 0;
            mon_abort = 1'b1;
        end else begin
            pop_now  = (e >= m_free_at) && (m_fifo.size() > 0);
            was_full = (m_fifo.size() == D);
            if (we && address == BASE && was_full && !pop_now) m_ovf = 1'b1;
            if (pop_now) begin
                exp_q.push_back('{data: m_fifo.pop_front(), start: e});
                m_free_at = e + FRAME + 1;
            end
            if (we && address == BASE && (!was_full || pop_now)) m_fifo.push_back(wdata[7:0]);
            if (we && address == BASE + 32'd4 && wdata[3]) m_ovf = 1'b0;
        end
        m_busy = (e + 1 < m_free_at);
        cyc++;
    end

    // ---------------- line monitor ----------------
    bit         in_frame = 1'b0;
    bit         have_exp = 1'b0;
    int         k = 0;
    int         wave_err = 0;
    int         busy_err = 0;
    int         frames = 0;
    logic [7:0] got = '0;
    exp_t       cur;
    longint     cur_start = 0;
    longint     starts[$];

    always @(negedge clk) begin
        int   bi;
        logic expb;
        if (tx_busy !== m_busy) busy_err++;
        if (mon_abort) begin
            mon_abort = 1'b0;
            in_frame  = 1'b0;
            check("reset_tx_idle", {31'd0, tx}, 32'd1);
        end else if (!in_frame && tx === 1'b0) begin
            in_frame  = 1'b1;
            k         = 0;
            wave_err  = 0;
            got       = '0;
            cur_start = cyc - 1;
            if (exp_q.size() == 0) begin
                have_exp = 1'b0;
                checks++;
                failures++;
                $display("FAIL unexpected_frame: start at edge %0d, no byte expected", cur_start);
            end else begin
                have_exp = 1'b1;
                cur      = exp_q.pop_front();
            end
        end
        if (in_frame) begin
            bi = k / C;
            if (bi == 0) expb = 1'b0;
            else if (bi == 9) expb = 1'b1;
            else expb = cur.data[bi-1];
            if (have_exp && tx !== expb) wave_err++;
            if (bi >= 1 && bi <= 8 && (k % C) == C / 2) got[bi-1] = tx;
            k++;
            if (k == FRAME) begin
                in_frame = 1'b0;
                if (have_exp) begin
                    check("frame_data", {24'd0, got}, {24'd0, cur.data});
                    check("frame_wave", wave_err, 0);
                    check("frame_start", 32'(cur_start), 32'(cur.start));
                end
                starts.push_back(cur_start);
                frames++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        wdata   = d;
        we      = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            we      = 1'b0;
            address = '0;
        end
    endtask

    task automatic read_chk(input logic [31:0] a, input string name);
        logic [31:0] exp_rd;
        logic        exp_sel;
        @(negedge clk);
        we      = 1'b0;
        address = a;
        #1;
        exp_sel = (a == BASE) || (a == BASE + 32'd4);
        exp_rd  = (a == BASE + 32'd4) ? model_status() : 32'd0;
        check({name, "_rdata"}, rdata, exp_rd);
        check({name, "_sel"}, {31'd0, sel}, {31'd0, exp_sel});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((m_fifo.size() != 0 || m_busy || in_frame || exp_q.size() != 0) && n < budget) begin
            idle(1);
            n++;
        end
        if (n >= budget) check("drain_timeout", 32'd1, 32'd0);
        idle(2);
    endtask

    initial begin
        int n;
        int f0;
        int s0;
        idle(3);
        reset = 1'b0;

        // Reset state and decode
        read_chk(BASE + 32'd4, "reset_status");
        check("reset_status_lit", rdata, 32'h0000_0002);
        check("reset_tx", {31'd0, tx}, 32'd1);
        read_chk(BASE + 32'd8, "nomatch_base8");
        read_chk(BASE, "txdata_read");
        read_chk(BASE + 32'd5, "nomatch_base5");

        // Single frame 0xA5
        store(BASE, 32'hFFFF_FFA5);
        read_chk(BASE + 32'd4, "after_push");
        drain(2000);

        // Back-to-back frames
        s0 = starts.size();
        store(BASE, 32'h41);
        store(BASE, 32'h42);
        idle(1);
        drain(2000);
        if (starts.size() >= s0 + 2)
            check("b2b_period", 32'(starts[s0+1] - starts[s0]), 32'(FRAME + 1));
        else
            check("b2b_frames", starts.size() - s0, 2);

        // Overflow: six consecutive stores, one dropped
        for (int i = 1; i <= 6; i++) store(BASE, i);
        read_chk(BASE + 32'd4, "ovf_status");
        check("ovf_bit", {31'd0, rdata[3]}, 32'd1);
        store(BASE + 32'd4, 32'h8);
        read_chk(BASE + 32'd4, "ovf_cleared");
        check("ovf_cleared_bit", {31'd0, rdata[3]}, 32'd0);
        drain(2000);

        // Push into a full FIFO on the exact pop edge
        for (int i = 0; i < 5; i++) store(BASE, 32'h60 + i);
        idle(1);
        n = 0;
        while (!(cyc == m_free_at && m_fifo.size() == D) && n < 200) begin
            idle(1);
            n++;
        end
        if (n >= 200) check("popedge_timeout", 32'd1, 32'd0);
        address = BASE;
        wdata   = 32'h7E;
        we      = 1'b1;
        read_chk(BASE + 32'd4, "popedge_status");
        check("popedge_no_ovf", {31'd0, rdata[3]}, 32'd0);
        drain(2000);

        // Reset mid-DATA with bytes queued
        store(BASE, 32'h11);
        store(BASE, 32'h22);
        store(BASE, 32'h33);
        idle(3 * C + 2);
        @(negedge clk);
        reset = 1'b1;
        we    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        f0    = frames;
        read_chk(BASE + 32'd4, "midreset_status");
        check("midreset_status_lit", rdata, 32'h0000_0002);
        idle(3 * FRAME);
        check("midreset_no_frames", frames, f0);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            if (r < 40) begin
                store(BASE, $urandom);
            end else if (r < 48) begin
                store(BASE + 32'd4, $urandom);
            end else if (r < 58) begin
                a = BASE + 32'($urandom_range(1, 8));
                if (a == BASE + 32'd4) a = BASE + 32'd3;
                store(a, $urandom);
            end else if (r < 78) begin
                case ($urandom_range(0, 3))
                    0: a = BASE;
                    1: a = BASE + 32'($urandom_range(1, 7));
                    2: a = $urandom;
                    default: a = BASE + 32'd4;
                endcase
                read_chk(a, "rand_read");
            end else begin
                idle($urandom_range(1, 20));
            end
        end
        idle(1);
        drain(4000);

        check("final_queue_empty", exp_q.size(), 0);
        check("busy_trace", busy_err, 0);
        read_chk(BASE + 32'd4, "final_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
